// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  localparam int DIV_WIDTH = 16;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvsr always holds, so the shifted value fits and bit WIDTH of trial is its sign
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: sign/magnitude capture, WIDTH restoring steps, sign fix-up on the last step.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dest_valid,
  input  logic             dest_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state, state_next;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r;
  logic             accept, zero_dvsr;

  assign accept       = src_valid && src_ready;
  assign zero_dvsr    = (divisor == '0);
  // the most negative value maps to 2^(WIDTH-1), which is still exact as unsigned
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvsr     (dvsr),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    src_ready  = 1'b0;
    dest_valid = 1'b0;
    case (state)
      IDLE: begin
        src_ready = 1'b1;
        if (src_valid) state_next = zero_dvsr ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        dest_valid = 1'b1;
        if (dest_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r <= dividend[WIDTH-1];
      rem    <= '0;
      quo    <= dividend_mag;
      dvsr   <= divisor_mag;
      cnt    <= '0;
      if (zero_dvsr) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == BUSY) begin
      rem <= rem_step;
      quo <= quo_step;
      if (cnt == LAST) begin
        quotient    <= sign_q ? -quo_step : quo_step;
        remainder   <= sign_r ? -rem_step : rem_step;
        div_by_zero <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random checks of seq_signed_divider with hand-computed expectations.
module tb_seq_signed_divider;

  logic        clk;
  logic        rst_n;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        dest_valid;
  logic        dest_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_signed_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .dest_valid  (dest_valid),
    .dest_ready  (dest_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // called just after the accept edge; lat counts cycles from the accept cycle
  task automatic wait_done(output int lat);
    lat = 1;
    while (!dest_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    dest_ready = 1'b1;
    @(posedge clk); #1;
    dest_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input int a, input int b,
                       input int eq, input int er, input logic ez, input int elat);
    logic [15:0] eq16, er16;
    int lat;
    eq16 = eq[15:0];
    er16 = er[15:0];
    dividend  = a[15:0];
    divisor   = b[15:0];
    src_valid = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"},   32'(quotient), 32'(eq16));
    check({tag, "_r"},   32'(remainder), 32'(er16));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    if (dest_valid) handshake();
  endtask

  initial begin
    int lat;
    int sa, sb, eq, er, qo, ro, inv;
    logic [15:0] a16, b16;

    rst_n      = 1'b0;
    src_valid  = 1'b0;
    dest_ready = 1'b0;
    dividend   = '0;
    divisor    = '0;
    #1;
    check("rst_src_ready",  32'(src_ready), 32'd1);
    check("rst_dest_valid", 32'(dest_valid), 32'd0);
    check("rst_q",          32'(quotient), 32'd0);
    check("rst_r",          32'(remainder), 32'd0);
    check("rst_dbz",        32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("pp",   100,  7,  14,  2, 1'b0, 17);
    do_op("np",  -100,  7, -14, -2, 1'b0, 17);
    do_op("pn",   100, -7, -14,  2, 1'b0, 17);
    do_op("nn",  -100, -7,  14, -2, 1'b0, 17);
    do_op("dz",  1234,  0,  -1, 1234, 1'b1, 1);
    do_op("dzn",  -5,   0,  -1, -5, 1'b1, 1);
    do_op("ovf", -32768, -1, -32768, 0, 1'b0, 17);
    do_op("min1", -32768, 1, -32768, 0, 1'b0, 17);
    do_op("small", 3, 7, 0, 3, 1'b0, 17);
    do_op("max", 32767, -32768, 0, 32767, 1'b0, 17);

    // backpressure, then a second op queued on src_valid during DONE
    dividend  = 16'd1000;
    divisor   = -16'sd3;
    src_valid = 1'b1;
    @(posedge clk); #1;
    dividend  = 16'd50;
    divisor   = 16'd5;
    wait_done(lat);
    check("bp_lat", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_q",     32'(quotient), 32'(16'hFEB3));
      check("bp_hold_r",     32'(remainder), 32'd1);
      check("bp_hold_valid", 32'(dest_valid), 32'd1);
      check("bp_src_ready",  32'(src_ready), 32'd0);
    end
    handshake();
    check("b2b_ready_idle", 32'(src_ready), 32'd1);
    @(posedge clk); #1;
    src_valid = 1'b0;
    check("b2b_accepted", 32'(src_ready), 32'd0);
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'd17);
    check("b2b_q",   32'(quotient), 32'd10);
    check("b2b_r",   32'(remainder), 32'd0);
    handshake();

    // reset in the middle of a division
    dividend  = 16'd100;
    divisor   = 16'd7;
    src_valid = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_dest_valid", 32'(dest_valid), 32'd0);
    check("abort_src_ready",  32'(src_ready), 32'd1);
    check("abort_q",          32'(quotient), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(dest_valid), 32'd0);
    end
    do_op("post", 9, 3, 3, 0, 1'b0, 17);

    for (int i = 0; i < 300; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      case (i % 8)
        0: b16 = '0;
        1: b16 = 16'($urandom_range(1, 20));
        2: b16 = 16'hFFFF;
        3: a16 = 16'h8000;
        default: ;
      endcase
      sa = int'($signed(a16));
      sb = int'($signed(b16));
      if (sb == 0) begin
        eq = -1;
        er = sa;
      end else begin
        eq = sa / sb;
        er = sa % sb;
      end
      do_op("rnd", sa, sb, eq, er, (sb == 0), (sb == 0) ? 1 : 17);
      if (sb != 0) begin
        qo  = int'($signed(quotient));
        ro  = int'($signed(remainder));
        inv = qo * sb + ro;
        check("rnd_inv", 32'(inv[15:0]), 32'(a16));
        check("rnd_rem_lt", 32'((ro < 0 ? -ro : ro) < (sb < 0 ? -sb : sb)), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
